seven_seg_scan_driver: RTL and testbench

- Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display.
- Captures a packed nibble vector on a load strobe and scans one digit at a time at a programmable refresh rate.
- Decodes each nibble to segments (0-9 and optionally A-F), with per-digit decimal points, leading-zero suppression and global blanking.
- Sits between the ALU result/status registers and the board display pins.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_glyph_rom.sv | 22 ++
 rtl/seven_seg_scan_driver.sv | 135 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and nibble encoder.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  function automatic logic [6:0] seg7_encode(
    input logic [3:0] i_nib,
    input logic       i_hex_en
  );
    logic [6:0] w_glyph;
    w_glyph = SEG_BLANK;
    unique case (i_nib)
      4'h0: w_glyph = GLYPH_0;
      4'h1: w_glyph = GLYPH_1;
      4'h2: w_glyph = GLYPH_2;
      4'h3: w_glyph = GLYPH_3;
      4'h4: w_glyph = GLYPH_4;
      4'h5: w_glyph = GLYPH_5;
      4'h6: w_glyph = GLYPH_6;
      4'h7: w_glyph = GLYPH_7;
      4'h8: w_glyph = GLYPH_8;
      4'h9: w_glyph = GLYPH_9;
      4'hA: if (i_hex_en) w_glyph = GLYPH_A;
      4'hB: if (i_hex_en) w_glyph = GLYPH_B;
      4'hC: if (i_hex_en) w_glyph = GLYPH_C;
      4'hD: if (i_hex_en) w_glyph = GLYPH_D;
      4'hE: if (i_hex_en) w_glyph = GLYPH_E;
      4'hF: if (i_hex_en) w_glyph = GLYPH_F;
    endcase
    return w_glyph;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational nibble-to-segment lookup with pin polarity.
// i_off forces every segment to its inactive level.
module seg7_glyph_rom
  import seg7_pkg::*;
#(
  parameter bit HEX_EN         = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_off,
  output logic [6:0] o_seg
);

  logic [6:0] w_glyph;

  always_comb begin
    w_glyph = SEG_BLANK;
    if (!i_off) w_glyph = seg7_encode(i_nibble, HEX_EN);
    o_seg = SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// New values are staged and only shown from a frame boundary.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_disp_val;
  logic [DIGITS-1:0]   r_disp_dp;
  logic [4*DIGITS-1:0] r_pend_val;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_v;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_fd;

  logic                w_adv;
  logic                w_wrap;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_zero_from;
  logic                w_acc;
  logic                w_sup;
  logic                w_off;
  logic [6:0]          w_seg;

  assign w_adv  = (r_cnt == CNT_LAST);
  assign w_wrap = w_adv && (r_idx == IDX_LAST);

  // w_zero_from[i]: every nibble at index >= i is zero
  always_comb begin
    w_acc       = 1'b1;
    w_zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_acc          = w_acc && (r_disp_val[4*i +: 4] == 4'h0);
      w_zero_from[i] = w_acc;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_onehot = '0;
    w_sup    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_dp_sel    = r_disp_dp[i];
        w_onehot[i] = 1'b1;
      end
    end
    for (int i = 1; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_sup = w_zero_from[i];
    end
  end

  assign w_off = lz_en && w_sup;

  seg7_glyph_rom #(
    .HEX_EN         (HEX_EN != 0),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
  ) u_rom (
    .i_nibble (w_nib),
    .i_off    (w_off),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_v   <= 1'b0;
      r_seg      <= {7{SEG_OFF}};
      r_dp       <= SEG_OFF;
      r_an       <= AN_OFF;
      r_fd       <= 1'b0;
    end else begin
      r_cnt <= w_adv ? '0 : r_cnt + 1'b1;
      if (w_adv) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      r_fd <= w_wrap;
      if (w_wrap && r_pend_v) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_pend_v   <= 1'b0;
      end
      // a load on the wrap cycle still wins the pending slot
      if (load) begin
        r_pend_val <= value_in;
        r_pend_dp  <= dp_in;
        r_pend_v   <= 1'b1;
      end
      r_seg <= w_seg;
      r_dp  <= (w_dp_sel && !w_off) ^ SEG_OFF;
      r_an  <= blank ? AN_OFF : (w_onehot ^ AN_OFF);
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: table vectors, corner
// sequences and random stimulus against a time-based model.
module tb_seven_seg_scan_driver;

  localparam int D  = 4;
  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic        blank;
  logic [6:0]  seg, seg_h;
  logic        dp, dp_h;
  logic [3:0]  an, an_h;
  logic        fd, fd_h;

  seven_seg_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(RD), .HEX_EN(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in),
    .load(load), .lz_en(lz_en), .blank(blank),
    .seg(seg), .dp(dp), .an(an), .frame_done(fd)
  );

  seven_seg_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(RD), .HEX_EN(0),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_nohex (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in),
    .load(load), .lz_en(lz_en), .blank(blank),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [6:0] glyph_tab [16];

  // model: k counts clock edges since reset release
  int          m_k;
  logic [15:0] m_dv, m_pval;
  logic [3:0]  m_dd, m_pdp;
  bit          m_pv;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        lz;
    logic [27:0] s1;
    logic [27:0] s0;
    logic [3:0]  dpo;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] pin_seg(input logic [3:0] nib,
                                         input bit hx);
    if (nib > 4'h9 && !hx) return 7'h7F;
    return ~glyph_tab[nib];
  endfunction

  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg, e_seg0;
    logic       e_dp, e_fd;
    logic [3:0] nib;
    int         idx;
    bit         wrap, sup;
    if (rst) begin
      m_k = 0; m_dv = '0; m_dd = '0;
      m_pval = '0; m_pdp = '0; m_pv = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_seg0 = 7'h7F;
      e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      idx  = (m_k / RD) % D;
      wrap = (m_k % (RD * D)) == (RD * D - 1);
      nib  = 4'(m_dv >> (4 * idx));
      sup  = lz_en && idx != 0 && (m_dv >> (4 * idx)) == 0;
      e_an   = blank ? 4'hF : ~(4'b0001 << idx);
      e_seg  = sup ? 7'h7F : pin_seg(nib, 1);
      e_seg0 = sup ? 7'h7F : pin_seg(nib, 0);
      e_dp   = sup ? 1'b1 : ~m_dd[idx];
      e_fd   = wrap;
      if (wrap && m_pv) begin
        m_dv = m_pval; m_dd = m_pdp; m_pv = 0;
      end
      if (load) begin
        m_pval = value_in; m_pdp = dp_in; m_pv = 1;
      end
      m_k++;
    end
    @(posedge clk);
    #1;
    chk("model_out", {19'b0, an, seg, dp, fd},
        {19'b0, e_an, e_seg, e_dp, e_fd});
    chk("model_nohex_seg", {25'b0, seg_h}, {25'b0, e_seg0});
  endtask

  task automatic sync_fd(output int n);
    n = 0;
    while (fd !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("fd_seen", {31'b0, fd}, 32'd1);
  endtask

  initial begin
    int n, n2, stale;
    logic [3:0]  an_exp;
    logic [15:0] masks [5];
    vec_t v;

    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                  7'h39, 7'h5E, 7'h79, 7'h71};
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    vecs[0] = '{16'h1234, 4'b0000, 1'b0,
      {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
      {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0000, 1'b0,
      {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001},
      {4{7'b1111111}}, 4'b1111};
    vecs[2] = '{16'h0070, 4'b0000, 1'b1,
      {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000},
      {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1,
      {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
      {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[4] = '{16'h8765, 4'b0101, 1'b0,
      {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010},
      {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010}, 4'b1010};
    vecs[5] = '{16'h0005, 4'b1000, 1'b1,
      {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010},
      {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'b1111};
    vecs[6] = '{16'hF0E0, 4'b0000, 1'b1,
      {7'b0001110, 7'b1000000, 7'b0000110, 7'b1000000},
      {7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000}, 4'b1111};

    rst = 1'b1; value_in = '0; dp_in = '0;
    load = 1'b0; lz_en = 1'b0; blank = 1'b0;
    tick();
    tick();
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_seg_dp_fd", {23'b0, seg, dp, fd}, {23'b0, 7'h7F, 2'b10});

    rst = 1'b0;
    tick();
    chk("first_digit", {21'b0, an, seg}, {21'b0, 4'b1110, 7'b1000000});
    value_in = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("hold_old", {21'b0, an, seg}, {21'b0, 4'b1110, 7'b1000000});

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      lz_en = v.lz;
      sync_fd(n);
      value_in = v.val; dp_in = v.dpi; load = 1'b1;
      tick();
      load = 1'b0;
      sync_fd(n);
      tick();
      for (int d = 0; d < D; d++) begin
        an_exp = ~(4'b0001 << d);
        chk("vec_an", {28'b0, an}, {28'b0, an_exp});
        chk("vec_seg", {25'b0, seg}, {25'b0, v.s1[7*d +: 7]});
        chk("vec_seg_nohex", {25'b0, seg_h}, {25'b0, v.s0[7*d +: 7]});
        chk("vec_dp", {31'b0, dp}, {31'b0, v.dpo[d]});
        if (d < D - 1) repeat (RD) tick();
      end
    end
    lz_en = 1'b0;

    // load landing exactly on the wrap cycle
    sync_fd(n);
    value_in = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (14) tick();
    value_in = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    chk("wrap_fd", {31'b0, fd}, 32'd1);
    tick();
    chk("wrap_old_pend", {21'b0, an, seg}, {21'b0, 4'b1110, 7'b0100100});
    sync_fd(n);
    chk("fd_period", n + 1, 16);
    tick();
    chk("wrap_new_pend", {21'b0, an, seg}, {21'b0, 4'b1110, 7'b1111001});

    // blanking keeps the scan running
    sync_fd(n);
    blank = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("blank_an", {28'b0, an}, 32'hF);
    end
    blank = 1'b0;
    tick();
    chk("resume_idx", {28'b0, an}, {28'b0, 4'b1011});
    sync_fd(n);
    chk("blank_fd_period", n, 5);

    // reset mid-frame discards pending
    sync_fd(n);
    value_in = 16'h9999; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_an", {28'b0, an}, 32'hF);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (seg == 7'b0010000) stale++;
    end
    chk("no_stale_pending", stale, 0);
    sync_fd(n);
    sync_fd(n2);
    tick();
    chk("post_rst_zero", {21'b0, an, seg}, {21'b0, 4'b1110, 7'b1000000});

    for (int t = 0; t < 800; t++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 5) == 0);
      value_in = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 29) == 0) blank = ~blank;
      tick();
    end
    rst = 1'b0; load = 1'b0; blank = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
